// File: rtl/gcd_pkg.sv
// Shared state encoding and sizing helper for the Stein binary GCD unit.
package gcd_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ZCHK   = 2'd1;
   localparam logic [1:0] ST_COMMON = 2'd2;
   localparam logic [1:0] ST_REDUCE = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      ZCHK   = ST_ZCHK,
      COMMON = ST_COMMON,
      REDUCE = ST_REDUCE
   } gcd_state_e;

   // The shared power-of-two exponent never exceeds WIDTH, so clog2+1 bits hold it.
   function automatic int k_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/gcd_stein_step.sv
// One combinational iteration of Stein's algorithm: either strip a common factor
// of two (COMMON) or perform one shift/subtract reduction step (REDUCE).
module gcd_stein_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             reduce_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             k_inc_o,
   output logic             finish_o
);

   logic [WIDTH-1:0] diff_ab;
   logic [WIDTH-1:0] diff_ba;

   assign diff_ab = a_i - b_i;
   assign diff_ba = b_i - a_i;

   always_comb begin
      a_o      = a_i;
      b_o      = b_i;
      k_inc_o  = 1'b0;
      finish_o = 1'b0;
      if (!reduce_i) begin
         // finish_o here means "leave COMMON"; operands stay untouched that cycle
         if (!a_i[0] && !b_i[0]) begin
            a_o     = a_i >> 1;
            b_o     = b_i >> 1;
            k_inc_o = 1'b1;
         end else begin
            finish_o = 1'b1;
         end
      end else begin
         if (a_i == '0) begin
            finish_o = 1'b1;
         end else if (!a_i[0]) begin
            a_o = a_i >> 1;
         end else if (!b_i[0]) begin
            b_o = b_i >> 1;
         end else if (a_i >= b_i) begin
            a_o = diff_ab >> 1;
         end else begin
            b_o = diff_ba >> 1;
         end
      end
   end

endmodule

// File: rtl/gcd_stein.sv
// Stein binary GCD with Go/Busy/Done handshake, zero-operand detection and a
// saturating count of the cycles spent in COMMON plus REDUCE.
module gcd_stein
   import gcd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 6
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Go,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic             ZeroErr,
   output logic [CNT_W-1:0] Cycles
);

   localparam int KW = k_width(WIDTH);

   gcd_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [KW-1:0]    k_q, k_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cyc_q, cyc_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zerr_q, zerr_d, done_q, done_d;

   logic [WIDTH-1:0] step_a, step_b;
   logic             step_kinc, step_fin;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   gcd_stein_step #(.WIDTH(WIDTH)) u_step (
      .a_i      (a_q),
      .b_i      (b_q),
      .reduce_i (state_q == REDUCE),
      .a_o      (step_a),
      .b_o      (step_b),
      .k_inc_o  (step_kinc),
      .finish_o (step_fin)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      cyc_d   = cyc_q;
      res_d   = res_q;
      zerr_d  = zerr_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (Go) begin
               a_d     = X;
               b_d     = Y;
               k_d     = '0;
               cnt_d   = '0;
               state_d = ZCHK;
            end
         end
         ZCHK: begin
            if (a_q == '0 || b_q == '0) begin
               // with at least one operand zero, OR yields the other one (or zero)
               res_d   = a_q | b_q;
               zerr_d  = (a_q == '0) && (b_q == '0);
               cyc_d   = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = COMMON;
            end
         end
         COMMON: begin
            cnt_d = sat_inc(cnt_q);
            a_d   = step_a;
            b_d   = step_b;
            k_d   = k_q + {{(KW-1){1'b0}}, step_kinc};
            if (step_fin) begin
               state_d = REDUCE;
            end
         end
         REDUCE: begin
            cnt_d = sat_inc(cnt_q);
            if (step_fin) begin
               // reported count includes this final REDUCE cycle
               res_d   = b_q << k_q;
               zerr_d  = 1'b0;
               cyc_d   = sat_inc(cnt_q);
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               a_d = step_a;
               b_d = step_b;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         cyc_q   <= '0;
         res_q   <= '0;
         zerr_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         cyc_q   <= cyc_d;
         res_q   <= res_d;
         zerr_q  <= zerr_d;
         done_q  <= done_d;
      end
   end

   assign Busy    = (state_q != IDLE);
   assign Done    = done_q;
   assign Result  = res_q;
   assign ZeroErr = zerr_q;
   assign Cycles  = cyc_q;

endmodule

// File: tb/tb_gcd_stein.sv
// Directed and swept checks of gcd_stein at WIDTH=5 and WIDTH=8.
module tb_gcd_stein;

   logic       clk;
   logic       rst;
   logic [4:0] X5, Y5, Result5;
   logic       Go5, Busy5, Done5, ZeroErr5;
   logic [5:0] Cycles5;
   logic [7:0] X8, Y8, Result8;
   logic       Go8, Busy8, Done8, ZeroErr8;
   logic [5:0] Cycles8;

   int checks   = 0;
   int failures = 0;

   gcd_stein #(.WIDTH(5), .CNT_W(6)) u5 (
      .Clk(clk), .Reset(rst), .X(X5), .Y(Y5), .Go(Go5), .Busy(Busy5),
      .Done(Done5), .Result(Result5), .ZeroErr(ZeroErr5), .Cycles(Cycles5)
   );

   gcd_stein #(.WIDTH(8), .CNT_W(6)) u8 (
      .Clk(clk), .Reset(rst), .X(X8), .Y(Y8), .Go(Go8), .Busy(Busy8),
      .Done(Done8), .Result(Result8), .ZeroErr(ZeroErr8), .Cycles(Cycles8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int gcd_ref(input int a, input int b);
      int t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Drives one WIDTH=5 operation and stops in the Done cycle.
   task automatic run5(input string tag, input int x, input int y, input int res,
                       input int cyc, input int lat, input int zerr);
      int n;
      X5 = x[4:0]; Y5 = y[4:0]; Go5 = 1'b1;
      tick();
      Go5 = 1'b0;
      chk({tag, "_busy"}, Busy5, 1);
      n = 0;
      while (!Done5 && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_res"}, Result5, res);
      chk({tag, "_cyc"}, Cycles5, cyc);
      chk({tag, "_zerr"}, ZeroErr5, zerr);
   endtask

   task automatic run8(input string tag, input int x, input int y);
      int n;
      X8 = x[7:0]; Y8 = y[7:0]; Go8 = 1'b1;
      tick();
      Go8 = 1'b0;
      n = 0;
      while (!Done8 && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_res"}, Result8, gcd_ref(x, y));
      chk({tag, "_zerr"}, ZeroErr8, (x == 0 && y == 0) ? 1 : 0);
      chk({tag, "_lat"}, n, 32'(Cycles8) + 1);
      chk({tag, "_cycmax"}, (Cycles8 <= 6'd18) ? 1 : 0, 1);
   endtask

   initial begin
      int ndone, first_n;
      rst = 1'b1; Go5 = 1'b0; Go8 = 1'b0;
      X5 = '0; Y5 = '0; X8 = '0; Y8 = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_busy", Busy5, 0);
      chk("rst_done", Done5, 0);
      chk("rst_res", Result5, 0);
      chk("rst_cyc", Cycles5, 0);
      chk("rst_zerr", ZeroErr5, 0);
      chk("rst_busy8", Busy8, 0);

      run5("g12_18", 12, 18, 6, 6, 7, 0);
      tick();
      chk("g12_18_pulse", Done5, 0);
      chk("g12_18_hold", Result5, 6);

      run5("g17_5", 17, 5, 1, 7, 8, 0);
      run5("g31_31", 31, 31, 31, 3, 4, 0);
      tick();
      chk("g31_31_pulse", Done5, 0);

      run5("z0_7", 0, 7, 7, 0, 1, 0);
      run5("z9_0", 9, 0, 9, 0, 1, 0);
      run5("z0_0", 0, 0, 0, 0, 1, 1);
      tick();
      chk("z0_0_hold_zerr", ZeroErr5, 1);
      chk("z0_0_hold_res", Result5, 0);

      // operand changes and extra Go while busy
      X5 = 5'd12; Y5 = 5'd18; Go5 = 1'b1;
      tick();
      Go5 = 1'b0; X5 = 5'd3; Y5 = 5'd4;
      tick();
      Go5 = 1'b1;
      tick();
      tick();
      Go5 = 1'b0;
      ndone = 0; first_n = 0;
      for (int i = 3; i < 16; i++) begin
         tick();
         if (Done5) begin
            ndone++;
            if (first_n == 0) first_n = i + 1;
         end
      end
      chk("busy_ign_ndone", ndone, 1);
      chk("busy_ign_lat", first_n, 7);
      chk("busy_ign_res", Result5, 6);

      // reset in the middle of REDUCE
      X5 = 5'd17; Y5 = 5'd5; Go5 = 1'b1;
      tick();
      Go5 = 1'b0;
      tick(); tick(); tick();
      chk("mid_busy_pre", Busy5, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_busy", Busy5, 0);
      chk("mid_done", Done5, 0);
      chk("mid_res", Result5, 0);
      chk("mid_cyc", Cycles5, 0);
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (Done5) ndone++;
      end
      chk("mid_nodone", ndone, 0);
      run5("after_rst", 12, 18, 6, 6, 7, 0);

      run8("w8_255", 255, 255);
      run8("w8_128_64", 128, 64);
      run8("w8_200_0", 200, 0);
      run8("w8_0_0", 0, 0);
      for (int i = 0; i < 1000; i++) begin
         run8("sweep", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
